counter_tick_gen: RTL and testbench

COUNTER_TICK_GEN -- requirements
Module: counter_tick_gen

---
 rtl/counter_tick_gen.sv | 137 +++++++++++++
 tb/tb_counter_tick_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_tick_gen.sv
// rtl/counter_tick_gen.sv - trigger-armed prescaled tick generator; optional trig_i synchronizer via COUNTER_TICK_GEN_TRIG_SYNC_EN
module counter_tick_gen #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             trig_i,
    input  logic             sw_start,
    input  logic             retrig_en,
    input  logic             done,
    output logic             start,
    output logic             timer_tick,
    output logic [1:0]       state,
    output logic [DIV_W-1:0] tick_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             start_q, start_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic             trig_prev_q, trig_prev_d;
    logic             trig_s;
    logic             trig_ev;

`ifdef COUNTER_TICK_GEN_TRIG_SYNC_EN
    logic trig_s1_q, trig_s1_d;
    logic trig_s2_q, trig_s2_d;

    always_comb begin
        trig_s1_d = trig_i;
        trig_s2_d = trig_s1_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
        end else begin
            trig_s1_q <= trig_s1_d;
            trig_s2_q <= trig_s2_d;
        end
    end

    assign trig_s = trig_s2_q;
`else
    assign trig_s = trig_i;
`endif

    // History tracks every cycle, so a level already high on entry to ARMED is not an edge.
    assign trig_ev = (trig_s & ~trig_prev_q) | sw_start;

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        tick_d      = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        presc_d     = presc_q;
        div_reg_d   = div_reg_q;
        trig_prev_d = trig_s;

        if (!enable) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_ev) begin
                        state_d    = ST_RUN;
                        start_d    = 1'b1;
                        div_reg_d  = div;
                        presc_d    = '0;
                        tick_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (retrig_en && trig_ev) begin
                        start_d    = 1'b1;
                        div_reg_d  = div;
                        presc_d    = '0;
                        tick_cnt_d = '0;
                    // done is stale while the downstream load pulse is out
                    end else if (done && !start_q) begin
                        state_d = retrig_en ? ST_ARMED : ST_DONE;
                        presc_d = '0;
                    end else if (presc_q == div_reg_q) begin
                        tick_d     = 1'b1;
                        presc_d    = '0;
                        tick_cnt_d = tick_cnt_q + DIV_W'(1);
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            tick_q      <= 1'b0;
            tick_cnt_q  <= '0;
            presc_q     <= '0;
            div_reg_q   <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            tick_q      <= tick_d;
            tick_cnt_q  <= tick_cnt_d;
            presc_q     <= presc_d;
            div_reg_q   <= div_reg_d;
            trig_prev_q <= trig_prev_d;
        end
    end

    assign start      = start_q;
    assign timer_tick = tick_q;
    assign state      = state_q;
    assign tick_cnt   = tick_cnt_q;

endmodule

// File: tb/tb_counter_tick_gen.sv
// tb/tb_counter_tick_gen.sv - scoreboard bench for counter_tick_gen
module tb_counter_tick_gen;

`ifdef COUNTER_TICK_GEN_TRIG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] div = '0;
    logic        trig_i = 1'b0;
    logic        sw_start = 1'b0;
    logic        retrig_en = 1'b0;
    logic        done = 1'b0;
    logic        start;
    logic        timer_tick;
    logic [1:0]  state;
    logic [31:0] tick_cnt;

    typedef struct {
        int cyc;
        bit st;
        int cnt;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  c;

    counter_tick_gen #(.DIV_W(32)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .div(div), .trig_i(trig_i),
        .sw_start(sw_start), .retrig_en(retrig_en), .done(done), .start(start),
        .timer_tick(timer_tick), .state(state), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int t);
        if (t > cyc) step(t - cyc);
    endtask

    task automatic push_ev(input int ecyc, input bit st, input int cnt);
        ev_t e;
        e.cyc = ecyc;
        e.st  = st;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rstn && (start || timer_tick)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {62'd0, start, timer_tick}, 64'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_start", start, e.st);
                check("ev_tick", timer_tick, !e.st);
                check("ev_cnt", tick_cnt, e.cnt);
            end
        end
    end

    initial begin
        // reset state
        step(2);
        check("rst_state", state, 0);
        check("rst_start", start, 0);
        check("rst_tick", timer_tick, 0);
        check("rst_cnt", tick_cnt, 0);
        rstn = 1'b1;
        step(1);
        check("idle_hold", state, 0);

        // sw_start, div=3: ticks every 4 cycles; div change mid-run ignored
        enable = 1'b1;
        div = 32'd3;
        step(1);
        check("armed", state, 1);
        sw_start = 1'b1;
        c = cyc + 1;
        push_ev(c, 1, 0);
        for (int k = 1; k <= 3; k++) push_ev(c + 4 * k, 0, k);
        step(1);
        sw_start = 1'b0;
        div = 32'd7;
        check("run", state, 2);
        step_to(c + 13);
        enable = 1'b0;
        step(1);
        check("dis_idle", state, 0);
        check("dis_cnt_hold", tick_cnt, 3);
        step(4);

        // trig_i edge, div=0, done after 5 ticks, no retrigger
        enable = 1'b1;
        div = 32'd0;
        retrig_en = 1'b0;
        step(1);
        trig_i = 1'b1;
        c = cyc + LAT;
        push_ev(c, 1, 0);
        for (int k = 1; k <= 5; k++) push_ev(c + k, 0, k);
        step_to(c + 5);
        done = 1'b1;
        step(1);
        check("done_state", state, 3);
        step(3);
        check("done_hold", state, 3);
        done = 1'b0;
        trig_i = 1'b0;
        enable = 1'b0;
        step(1);
        check("done_to_idle", state, 0);
        step(3);

        // retrigger mid-run after 2 ticks, div=2
        enable = 1'b1;
        retrig_en = 1'b1;
        div = 32'd2;
        step(1);
        sw_start = 1'b1;
        c = cyc + 1;
        push_ev(c, 1, 0);
        push_ev(c + 3, 0, 1);
        push_ev(c + 6, 0, 2);
        push_ev(c + 8, 1, 0);
        push_ev(c + 11, 0, 1);
        step(1);
        sw_start = 1'b0;
        step_to(c + 8 - LAT);
        trig_i = 1'b1;
        step_to(c + 11);
        done = 1'b1;
        step(1);
        check("rearm_state", state, 1);
        done = 1'b0;
        trig_i = 1'b0;
        retrig_en = 1'b0;
        step(4);
        check("rearm_hold", state, 1);

        // simultaneous trig_i edge and sw_start; done ignored during start
        div = 32'd1;
        trig_i = 1'b1;
        sw_start = 1'b1;
        done = 1'b1;
        c = cyc + 1;
        push_ev(c, 1, 0);
        push_ev(c + 2, 0, 1);
        push_ev(c + 4, 0, 2);
        step(1);
        sw_start = 1'b0;
        step(1);
        done = 1'b0;
        check("done_ignored", state, 2);

        // enable low mid-run, then reset
        step_to(c + 5);
        enable = 1'b0;
        step(1);
        check("abort_state", state, 0);
        check("abort_start", start, 0);
        check("abort_tick", timer_tick, 0);
        check("abort_cnt", tick_cnt, 2);
        trig_i = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst2_state", state, 0);
        check("rst2_cnt", tick_cnt, 0);
        step(2);
        rstn = 1'b1;
        step(1);

        // reset mid-run aborts with no further tick
        enable = 1'b1;
        div = 32'd0;
        step(1);
        sw_start = 1'b1;
        c = cyc + 1;
        push_ev(c, 1, 0);
        push_ev(c + 1, 0, 1);
        step(1);
        sw_start = 1'b0;
        step(1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst3_state", state, 0);
        check("rst3_tick", timer_tick, 0);
        check("rst3_cnt", tick_cnt, 0);
        step(3);
        check("rst3_hold_tick", timer_tick, 0);
        rstn = 1'b1;
        enable = 1'b0;
        step(2);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
